// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Control FSM for the instruction fetch stage. Drives the PC load enable, the
// PC-source select and the IF/ID load/clear controls from branch, halt and
// load-use hazard requests. After reset it holds fetch idle for BOOT_CYCLES
// cycles; after each taken branch it keeps IF/ID flushed for FLUSH_SLOTS
// cycles (redirect cycle included). Two saturating 16-bit counters record
// hazard-stall cycles and honored redirects for debug.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-low reset
//   branch_taken_in     resolved taken branch/jump this cycle
//   load_use_hazard_in  ID-stage load-use hazard (hold PC and IF/ID)
//   halt_in             stop fetching, sticky until reset
//   pc_write_out        PC register load enable
//   pc_src_out          PC mux select: 1 = branch target, 0 = PC+4
//   if_id_write_out     IF/ID register load enable
//   if_id_flush_out     IF/ID register clear (bubble insert)
//   state_out           BOOT=0, RUN=1, FLUSH=2, HALT=3
//   stall_count_out     saturating count of hazard-stall cycles
//   redirect_count_out  saturating count of honored redirects
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int BOOT_CYCLES = 2,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken_in,
  input  logic        load_use_hazard_in,
  input  logic        halt_in,
  output logic        pc_write_out,
  output logic        pc_src_out,
  output logic        if_id_write_out,
  output logic        if_id_flush_out,
  output logic [1:0]  state_out,
  output logic [15:0] stall_count_out,
  output logic [15:0] redirect_count_out
);

  // Configuration guard: out-of-range parameters stop elaboration.
  generate
    if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15) begin : g_bad_boot_cycles
      $error("fetch_sequencer: BOOT_CYCLES must be in 1..15");
    end
    if (FLUSH_SLOTS < 1 || FLUSH_SLOTS > 7) begin : g_bad_flush_slots
      $error("fetch_sequencer: FLUSH_SLOTS must be in 1..7");
    end
  endgenerate

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_LAST    = 4'(BOOT_CYCLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_SLOTS - 1);

  state_t      r_state;
  logic [3:0]  r_boot_cnt;
  logic [2:0]  r_flush_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_redirect_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // NOTE: every register here sits behind the synchronous reset branch and is
  // updated with non-blocking assignments, so all of them sample the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= BOOT;
      r_boot_cnt     <= '0;
      r_flush_cnt    <= '0;
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_boot_cnt <= r_boot_cnt + 4'd1;
          // Counter holds the number of boot cycles already completed.
          if (r_boot_cnt == BOOT_LAST) r_state <= RUN;
        end
        RUN: begin
          if (branch_taken_in) begin
            r_redirect_cnt <= sat_inc(r_redirect_cnt);
            if (FLUSH_SLOTS > 1) begin
              r_state     <= FLUSH;
              r_flush_cnt <= FLUSH_RELOAD;
            end
          end else if (halt_in) begin
            r_state <= HALT;
          end else if (load_use_hazard_in) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
          end
        end
        FLUSH: begin
          if (branch_taken_in) begin
            // A branch on a flush slot restarts the whole flush window.
            r_redirect_cnt <= sat_inc(r_redirect_cnt);
            r_flush_cnt    <= FLUSH_RELOAD;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
            if (r_flush_cnt <= 3'd1) r_state <= RUN;
          end
        end
        default: ;  // HALT: only reset leaves
      endcase
    end
  end

  // Mealy control outputs: registered state plus current requests.
  // NOTE: every output gets its BOOT value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write_out    = 1'b0;
    pc_src_out      = 1'b0;
    if_id_write_out = 1'b0;
    if_id_flush_out = 1'b1;
    if (reset) begin
      case (r_state)
        RUN: begin
          if (branch_taken_in) begin
            pc_write_out    = 1'b1;
            pc_src_out      = 1'b1;
            if_id_write_out = 1'b1;
            if_id_flush_out = 1'b1;
          end else if (halt_in) begin
            if_id_flush_out = 1'b1;
          end else if (load_use_hazard_in) begin
            if_id_flush_out = 1'b0;
          end else begin
            pc_write_out    = 1'b1;
            if_id_write_out = 1'b1;
            if_id_flush_out = 1'b0;
          end
        end
        FLUSH: begin
          pc_write_out    = 1'b1;
          pc_src_out      = branch_taken_in;
          if_id_write_out = 1'b1;
          if_id_flush_out = 1'b1;
        end
        default: ;  // BOOT and HALT keep the idle values
      endcase
    end
  end

  assign state_out          = r_state;
  assign stall_count_out    = r_stall_cnt;
  assign redirect_count_out = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A behavioural model tracks cycles
// since reset release, a halted flag, the number of flush cycles still owed
// and unbounded event counts (clipped to 16 bits on compare). Every cycle the
// model's expected outputs are compared with the DUT. Directed sequences with
// literal expectations pin the model; a randomized phase and a long hazard
// run exercise the remaining behaviour and counter saturation.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int BOOT_CYCLES = 2;
  localparam int FLUSH_SLOTS = 2;

  logic        clk;
  logic        reset;
  logic        branch_taken_in;
  logic        load_use_hazard_in;
  logic        halt_in;
  logic        pc_write_out;
  logic        pc_src_out;
  logic        if_id_write_out;
  logic        if_id_flush_out;
  logic [1:0]  state_out;
  logic [15:0] stall_count_out;
  logic [15:0] redirect_count_out;

  fetch_sequencer #(
    .BOOT_CYCLES(BOOT_CYCLES),
    .FLUSH_SLOTS(FLUSH_SLOTS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .branch_taken_in    (branch_taken_in),
    .load_use_hazard_in (load_use_hazard_in),
    .halt_in            (halt_in),
    .pc_write_out       (pc_write_out),
    .pc_src_out         (pc_src_out),
    .if_id_write_out    (if_id_write_out),
    .if_id_flush_out    (if_id_flush_out),
    .state_out          (state_out),
    .stall_count_out    (stall_count_out),
    .redirect_count_out (redirect_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit m_valid     = 1'b0;  // a reset edge has been seen
  int m_since_rel = 0;     // reset-high cycles completed since last reset
  bit m_halted    = 1'b0;
  int m_flush_due = 0;     // flush cycles owed after the current one
  int m_stalls    = 0;
  int m_redirects = 0;

  function automatic logic [15:0] clip16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  always @(negedge clk) begin
    logic       e_pw, e_src, e_ifw, e_fl, src_care;
    logic [1:0] e_state;
    logic       a_src;
    if (m_valid) begin
      e_pw = 1'b0; e_src = 1'b0; e_ifw = 1'b0; e_fl = 1'b1; src_care = 1'b1;
      if (m_since_rel < BOOT_CYCLES) e_state = 2'd0;
      else if (m_halted)             e_state = 2'd3;
      else if (m_flush_due > 0)      e_state = 2'd2;
      else                           e_state = 2'd1;
      if (reset) begin
        if (e_state == 2'd2) begin
          e_pw = 1'b1; e_ifw = 1'b1; e_fl = 1'b1; e_src = branch_taken_in;
        end else if (e_state == 2'd1) begin
          if (branch_taken_in) begin
            e_pw = 1'b1; e_src = 1'b1; e_ifw = 1'b1; e_fl = 1'b1;
          end else if (halt_in) begin
            e_fl = 1'b1; src_care = 1'b0;
          end else if (load_use_hazard_in) begin
            e_fl = 1'b0; src_care = 1'b0;
          end else begin
            e_pw = 1'b1; e_ifw = 1'b1; e_fl = 1'b0;
          end
        end
      end
      a_src = src_care ? pc_src_out : e_src;
      check("cycle_outputs",
            64'({pc_write_out, a_src, if_id_write_out, if_id_flush_out,
                 state_out, stall_count_out, redirect_count_out}),
            64'({e_pw, e_src, e_ifw, e_fl, e_state,
                 clip16(m_stalls), clip16(m_redirects)}));
    end

    // Advance the model to the state after the coming rising edge.
    if (!reset) begin
      m_valid = 1'b1; m_since_rel = 0; m_halted = 1'b0;
      m_flush_due = 0; m_stalls = 0; m_redirects = 0;
    end else if (m_since_rel < BOOT_CYCLES) begin
      m_since_rel++;
    end else if (m_halted) begin
      // stays halted
    end else if (m_flush_due > 0) begin
      if (branch_taken_in) begin
        m_redirects++;
        m_flush_due = FLUSH_SLOTS - 1;
      end else begin
        m_flush_due--;
      end
    end else if (branch_taken_in) begin
      m_redirects++;
      m_flush_due = FLUSH_SLOTS - 1;
    end else if (halt_in) begin
      m_halted = 1'b1;
    end else if (load_use_hazard_in) begin
      m_stalls++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Apply one cycle of inputs just after the rising edge, return at the
  // following falling edge where outputs are settled.
  task automatic cyc(input logic rst, input logic br, input logic hz, input logic ht);
    @(posedge clk);
    #1;
    reset = rst; branch_taken_in = br; load_use_hazard_in = hz; halt_in = ht;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < BOOT_CYCLES; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; branch_taken_in = 1'b0; load_use_hazard_in = 1'b0; halt_in = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Boot: cycles 0-1 idle, cycle 2 first fetch.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("boot_c0_pc_write", 64'(pc_write_out), 64'd0);
    check("boot_c0_flush",    64'(if_id_flush_out), 64'd1);
    check("boot_c0_state",    64'(state_out), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("boot_c1_state",    64'(state_out), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("boot_c2_pc_write", 64'(pc_write_out), 64'd1);
    check("boot_c2_state",    64'(state_out), 64'd1);

    // Single branch pulse.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("br_n_src",   64'(pc_src_out), 64'd1);
    check("br_n_flush", 64'(if_id_flush_out), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("br_n1_src",   64'(pc_src_out), 64'd0);
    check("br_n1_flush", 64'(if_id_flush_out), 64'd1);
    check("br_n1_state", 64'(state_out), 64'd2);
    check("br_n1_redir", 64'(redirect_count_out), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("br_n2_flush", 64'(if_id_flush_out), 64'd0);
    check("br_n2_state", 64'(state_out), 64'd1);

    // Branch and hazard together: branch wins, no stall counted.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("brhz_pc_write", 64'(pc_write_out), 64'd1);
    check("brhz_src",      64'(pc_src_out), 64'd1);
    check("brhz_flush",    64'(if_id_flush_out), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("brhz_stall", 64'(stall_count_out), 64'd0);
    check("brhz_redir", 64'(redirect_count_out), 64'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Hazard for 3 cycles, then back-to-back branches.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      check("hz_pc_write", 64'(pc_write_out), 64'd0);
      check("hz_ifid_write", 64'(if_id_write_out), 64'd0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("hz_stall3", 64'(stall_count_out), 64'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("b2b_state", 64'(state_out), 64'd2);
    check("b2b_src",   64'(pc_src_out), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("b2b_ext_state", 64'(state_out), 64'd2);
    check("b2b_ext_flush", 64'(if_id_flush_out), 64'd1);
    check("b2b_redir",     64'(redirect_count_out), 64'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("b2b_done_flush", 64'(if_id_flush_out), 64'd0);
    check("b2b_done_state", 64'(state_out), 64'd1);

    // Randomized traffic; the model compare covers every cycle.
    for (int i = 0; i < 4000; i++) begin
      int r_rst, r_br, r_hz, r_ht;
      r_rst = $urandom_range(0, 99);
      r_br  = $urandom_range(0, 99);
      r_hz  = $urandom_range(0, 99);
      r_ht  = $urandom_range(0, 99);
      cyc(r_rst >= 2, r_br < 20, r_hz < 30, r_ht < 2);
    end

    // Saturation of the stall counter, then halt and a short reset.
    do_reset();
    for (int i = 0; i < 70000; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("sat_stall", 64'(stall_count_out), 64'hFFFF);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("halt_req_pc_write", 64'(pc_write_out), 64'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("halt_state",    64'(state_out), 64'd3);
    check("halt_pc_write", 64'(pc_write_out), 64'd0);
    check("halt_sat_hold", 64'(stall_count_out), 64'hFFFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_state", 64'(state_out), 64'd0);
    check("rst_stall", 64'(stall_count_out), 64'd0);
    check("rst_redir", 64'(redirect_count_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
